// File: rtl/imem_loader_if.sv
// Byte-load handshake and instruction fetch bus of the instruction memory loader.
interface imem_loader_if #(parameter int ADDR_W = 5);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] read_addr;
  logic [15:0]       read_data;

  modport master (output rx_data, rx_valid, read_addr, input rx_ready, read_data);
  modport slave  (input rx_data, rx_valid, read_addr, output rx_ready, read_data);
endinterface

// File: rtl/imem_loader.sv
// Serial byte loader for a 16-bit instruction memory; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HIGH, LOW, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] mem [DEPTH];
  logic [7:0]  hi_q;
  logic [8:0]  len_q;
  logic        accept, last_word;

  assign accept    = bus.rx_valid && bus.rx_ready;
  // Last word when the post-write count reaches the program length.
  assign last_word = (32'(word_count) + 32'd1) >= 32'(len_q);
  assign bus.read_data = mem[bus.read_addr];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  assign bus.rx_ready = (state_q != DONE) && (state_q != ERROR);
`else
  assign bus.rx_ready = (state_q != DONE);
  assign load_error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = HIGH;
      HIGH: if (accept) state_d = LOW;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LOW:   if (accept) state_d = last_word ? CHECK : HIGH;
      CHECK: if (accept) state_d = (bus.rx_data == csum_q) ? DONE : ERROR;
`else
      LOW:  if (accept) state_d = last_word ? DONE : HIGH;
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      word_count <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: len_q <= (bus.rx_data == 8'd0) ? 9'(DEPTH) : {1'b0, bus.rx_data};
        HIGH: hi_q  <= bus.rx_data;
        LOW: begin
          mem[word_count[ADDR_W-1:0]] <= {hi_q, bus.rx_data};
          word_count <= word_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status flags track the next state so they switch on the edge entering DONE/ERROR.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
    end else begin
      cpu_reset <= (state_d != DONE);
      load_done <= (state_d == DONE);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q     <= '0;
      load_error <= 1'b0;
    end else begin
      if (accept && (state_q == IDLE || state_q == HIGH || state_q == LOW))
        csum_q <= csum_q ^ bus.rx_data;
      load_error <= (state_d == ERROR);
    end
  end
`endif

endmodule
